// File: rtl/regfile_mp.sv
// Multi-port register file with WAW issue scoreboard and a pending-register counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp #(
    parameter int N_REGS    = 32,
    parameter int REG_WIDTH = 32,
    parameter int N_RD      = 3,
    parameter int N_WR      = 2,
    localparam int AW       = $clog2(N_REGS),
    localparam int CW       = $clog2(N_REGS + 1)
) (
    input  logic                             iClk,
    input  logic                             iRst,
    input  logic [N_WR-1:0]                  iWriteEn,
    input  logic [N_WR-1:0][AW-1:0]          iWrAddr,
    input  logic [N_WR-1:0][REG_WIDTH-1:0]   iWrData,
    input  logic                             iWriteEn_dbg,
    input  logic [AW-1:0]                    iWrAddr_dbg,
    input  logic [REG_WIDTH-1:0]             iWrData_dbg,
    input  logic [N_RD-1:0][AW-1:0]          iRdAddr,
    output logic [N_RD-1:0][REG_WIDTH-1:0]   oRdData,
    output logic [N_RD-1:0]                  oRdBusy,
    input  logic                             iIssueEn,
    input  logic [AW-1:0]                    iIssueAddr,
    output logic                             oIssueStall,
    output logic [CW-1:0]                    oPendingCount
);

    logic [REG_WIDTH-1:0] regs_q [N_REGS];
    logic [REG_WIDTH-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0]    busy_q, busy_d;
    logic [N_REGS-1:0]    wr_hit;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        n_clr;
    logic                 issue_req, issue_ok;

    // Highest port index first so lower ports, then debug, overwrite it.
    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int p = N_WR - 1; p >= 0; p--) begin
            if (iWriteEn[p] && iWrAddr[p] != '0) begin
                regs_d[iWrAddr[p]] = iWrData[p];
                wr_hit[iWrAddr[p]] = 1'b1;
            end
        end
        if (iWriteEn_dbg && iWrAddr_dbg != '0) begin
            regs_d[iWrAddr_dbg] = iWrData_dbg;
            wr_hit[iWrAddr_dbg] = 1'b1;
        end
    end

    always_comb begin
        issue_req   = iIssueEn && (iIssueAddr != '0);
        oIssueStall = issue_req &&
                      (busy_q[iIssueAddr] || (iWriteEn_dbg && iIssueAddr == iWrAddr_dbg));
        issue_ok    = issue_req && !oIssueStall;
    end

    // An issue to an address, stalled or not, shields its busy bit from a writeback clear.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (issue_req) begin
            busy_d[iIssueAddr] = busy_q[iIssueAddr] | issue_ok;
        end
    end

    always_comb begin
        n_clr = '0;
        for (int a = 0; a < N_REGS; a++) begin
            n_clr = n_clr + CW'(busy_q[a] & ~busy_d[a]);
        end
        count_d = count_q + CW'(issue_ok) - n_clr;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int a = 0; a < N_REGS; a++) begin
                regs_q[a] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < N_RD; k++) begin
            oRdBusy[k] = busy_q[iRdAddr[k]];
            if (iRdAddr[k] == '0) begin
                oRdData[k] = '0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                oRdData[k] = regs_d[iRdAddr[k]];
`else
                oRdData[k] = regs_q[iRdAddr[k]];
`endif
            end
        end
    end

    assign oPendingCount = count_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        we;
    logic [1:0][4:0]   wa;
    logic [1:0][31:0]  wd;
    logic              dwe;
    logic [4:0]        dwa;
    logic [31:0]       dwd;
    logic [2:0][4:0]   ra;
    logic [2:0][31:0]  rd;
    logic [2:0]        rbusy;
    logic              ie;
    logic [4:0]        ia;
    logic              stall;
    logic [5:0]        cnt;

    logic [31:0] mreg [32];
    bit          mbusy [32];
    int          n_chk  = 0;
    int          n_fail = 0;

    regfile_mp dut (
        .iClk(clk), .iRst(rst),
        .iWriteEn(we), .iWrAddr(wa), .iWrData(wd),
        .iWriteEn_dbg(dwe), .iWrAddr_dbg(dwa), .iWrData_dbg(dwd),
        .iRdAddr(ra), .oRdData(rd), .oRdBusy(rbusy),
        .iIssueEn(ie), .iIssueAddr(ia), .oIssueStall(stall),
        .oPendingCount(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Winning write for address a: debug first, then port 0, then port 1.
    function automatic logic [32:0] writer(input int a);
        if (a == 0) return 33'd0;
        if (dwe && int'(dwa) == a) return {1'b1, dwd};
        for (int p = 0; p < 2; p++)
            if (we[p] && int'(wa[p]) == a) return {1'b1, wd[p]};
        return 33'd0;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int a = 0; a < 32; a++) n += int'(mbusy[a]);
        return n;
    endfunction

    function automatic bit exp_stall();
        if (!ie || ia == 5'd0) return 1'b0;
        return mbusy[ia] || (dwe && dwa == ia);
    endfunction

    task automatic idle();
        rst = 1'b0; we = '0; wa = '0; wd = '0;
        dwe = 1'b0; dwa = '0; dwd = '0;
        ra = '0; ie = 1'b0; ia = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int a;
            logic [32:0] w;
            logic [31:0] e;
            a = int'(ra[k]);
            w = writer(a);
            if (a == 0) e = '0;
            else if (BYP && w[32]) e = w[31:0];
            else e = mreg[a];
            chk($sformatf("rd%0d_x%0d", k, a), rd[k], e);
            chk($sformatf("busy%0d_x%0d", k, a), {31'd0, rbusy[k]}, {31'd0, (a != 0) && mbusy[a]});
        end
        chk("stall", {31'd0, stall}, {31'd0, exp_stall()});
        chk("count", {26'd0, cnt}, pending());
    endtask

    task automatic tick();
        bit st;
        logic [32:0] w;
        st = exp_stall();
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                mreg[a] = '0;
                mbusy[a] = 1'b0;
            end
        end else begin
            for (int a = 1; a < 32; a++) begin
                w = writer(a);
                if (w[32]) mreg[a] = w[31:0];
                if (ie && int'(ia) == a) begin
                    if (!st) mbusy[a] = 1'b1;
                end else if (w[32]) begin
                    mbusy[a] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        idle();
        settle(); chk("reset_count", {26'd0, cnt}, 32'd0); tick();

        idle(); we = 2'b11; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; wa[1] = 5'd5; wd[1] = 32'h1234;
        settle(); tick();
        idle(); ra[0] = 5'd5;
        settle(); chk("x5_port_pri", rd[0], 32'hDEADBEEF); tick();
        idle(); we = 2'b11; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; wa[1] = 5'd5; wd[1] = 32'h1234;
        dwe = 1'b1; dwa = 5'd5; dwd = 32'hA5;
        settle(); tick();
        idle(); ra[0] = 5'd5;
        settle(); chk("x5_dbg_pri", rd[0], 32'hA5); tick();

        idle(); we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ie = 1'b1; ia = 5'd0;
        settle(); chk("x0_no_stall", {31'd0, stall}, 32'd0); tick();
        idle();
        settle(); chk("x0_read", rd[0], 32'd0); chk("x0_busy", {31'd0, rbusy[0]}, 32'd0);
        chk("x0_count", {26'd0, cnt}, 32'd0); tick();

        idle(); ie = 1'b1; ia = 5'd7; settle(); tick();
        idle(); ie = 1'b1; ia = 5'd7; ra[1] = 5'd7;
        settle(); chk("x7_busy", {31'd0, rbusy[1]}, 32'd1); chk("x7_count1", {26'd0, cnt}, 32'd1);
        chk("x7_waw_stall", {31'd0, stall}, 32'd1); tick();
        idle(); ra[1] = 5'd7;
        settle(); chk("x7_count_after_stall", {26'd0, cnt}, 32'd1); tick();
        idle(); we = 2'b10; wa[1] = 5'd7; wd[1] = 32'h77; settle(); tick();
        idle(); ra[1] = 5'd7;
        settle(); chk("x7_cleared", {31'd0, rbusy[1]}, 32'd0); chk("x7_count0", {26'd0, cnt}, 32'd0); tick();

        idle(); ie = 1'b1; ia = 5'd9; settle(); tick();
        idle(); we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h99; ie = 1'b1; ia = 5'd9; settle(); tick();
        idle(); ra[2] = 5'd9;
        settle(); chk("x9_still_busy", {31'd0, rbusy[2]}, 32'd1); chk("x9_count", {26'd0, cnt}, 32'd1); tick();
        idle(); ie = 1'b1; ia = 5'd3; settle(); tick();
        idle(); we = 2'b01; wa[0] = 5'd3; wd[0] = 32'h33; ie = 1'b1; ia = 5'd4; settle(); tick();
        idle(); settle(); chk("wb3_iss4_count", {26'd0, cnt}, 32'd2); tick();
        idle(); we = 2'b11; wa[0] = 5'd4; wa[1] = 5'd9; settle(); tick();
        idle(); settle(); chk("drain_count", {26'd0, cnt}, 32'd0); tick();

        idle(); we = 2'b01; wa[0] = 5'd2; wd[0] = 32'h55; ra[0] = 5'd2;
        settle(); chk("x2_same_cycle", rd[0], BYP ? 32'h55 : 32'h0); tick();
        idle(); ra[0] = 5'd2;
        settle(); chk("x2_next_cycle", rd[0], 32'h55); tick();

        for (int i = 1; i < 32; i++) begin
            idle(); ie = 1'b1; ia = 5'(i); settle(); tick();
        end
        idle(); rst = 1'b1; we = 2'b01; wa[0] = 5'd6; wd[0] = 32'hCAFE;
        settle(); chk("full_count", {26'd0, cnt}, 32'd31); tick();
        idle(); ra[0] = 5'd6; ra[1] = 5'd5; ra[2] = 5'd31;
        settle(); chk("rst_count", {26'd0, cnt}, 32'd0); chk("rst_x6_dropped", rd[0], 32'd0);
        chk("rst_x31_busy", {31'd0, rbusy[2]}, 32'd0); tick();

        for (int c = 0; c < 400; c++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            we  = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wa[p] = 5'($urandom_range(0, 31));
                wd[p] = $urandom;
            end
            dwe = ($urandom_range(0, 7) == 0);
            dwa = 5'($urandom_range(0, 31));
            dwd = $urandom;
            for (int k = 0; k < 3; k++) ra[k] = 5'($urandom_range(0, 31));
            ie = ($urandom_range(0, 2) != 0);
            ia = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ia = dwa;
            if ($urandom_range(0, 3) == 0) ia = wa[0];
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
